cpu_mult_pipe: RTL and testbench

CPU_MULT_PIPE -- requirements
Module: cpu_mult_pipe

---
 rtl/cpu_mult_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_mult_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mult_pipe.sv
// cpu_mult_pipe: pipelined integer multiplier for a CPU execute stage.
// Supports MUL / MULH / MULHSU / MULHU, a sideband tag, valid/ready
// handshakes at both ends, flush, and a STAGES-deep pipeline that stalls
// as one unit whenever the output holds a result the consumer does not take.
// Optional feature: define CPU_MULT_PIPE_OVF_EN to add out_ovf, the signed
// overflow flag for the low-word MUL.
//
// The product is built from four half-width partial products. Signed
// operands are handled by subtracting the other operand, shifted up by
// DATA_W, for every negative signed input. That correction only touches the
// high word, so the low word is the same for every opcode.
// With STAGES > 1 the partial products are registered in the first stage
// and summed in the second. Further stages only delay the finished word.
// With STAGES == 1 the whole multiply happens ahead of the single register.

module cpu_mult_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
`ifdef CPU_MULT_PIPE_OVF_EN
    ,
    output logic              out_ovf
`endif
);

    localparam int HALF_W     = DATA_W / 2;
    localparam int RES_STAGES = (STAGES > 1) ? STAGES - 1 : 1;

    generate
        if ((DATA_W % 2) != 0 || DATA_W < 8 || DATA_W > 64 || STAGES < 1 || STAGES > 4) begin : g_bad_param
            $error("cpu_mult_pipe: illegal DATA_W or STAGES");
        end
    endgenerate

    logic advance;

    logic [DATA_W-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
    logic [DATA_W-1:0] corr_d;
    logic              sign_a, sign_b;

    logic [DATA_W-1:0] pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s;
    logic [DATA_W-1:0] corr_s;
    logic [1:0]        op_s;

    logic [2*DATA_W-1:0] full_prod;
    logic [DATA_W-1:0]   res_d;

    logic              vld_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [DATA_W-1:0] res_q [RES_STAGES];

`ifdef CPU_MULT_PIPE_OVF_EN
    logic ovf_d;
    logic ovf_q [RES_STAGES];
`endif

    // The whole pipeline moves together when the output slot is free or draining.
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Partial products and the signed correction term, taken from the raw operands.
    always_comb begin
        pp_ll_d = {{HALF_W{1'b0}}, in_src1[HALF_W-1:0]}      * {{HALF_W{1'b0}}, in_src2[HALF_W-1:0]};
        pp_lh_d = {{HALF_W{1'b0}}, in_src1[HALF_W-1:0]}      * {{HALF_W{1'b0}}, in_src2[DATA_W-1:HALF_W]};
        pp_hl_d = {{HALF_W{1'b0}}, in_src1[DATA_W-1:HALF_W]} * {{HALF_W{1'b0}}, in_src2[HALF_W-1:0]};
        pp_hh_d = {{HALF_W{1'b0}}, in_src1[DATA_W-1:HALF_W]} * {{HALF_W{1'b0}}, in_src2[DATA_W-1:HALF_W]};
        sign_a  = in_src1[DATA_W-1] & (in_op != 2'b11);
`ifdef CPU_MULT_PIPE_OVF_EN
        // MUL is treated as signed x signed so its high word can flag overflow.
        sign_b  = in_src2[DATA_W-1] & ((in_op == 2'b01) | (in_op == 2'b00));
`else
        sign_b  = in_src2[DATA_W-1] & (in_op == 2'b01);
`endif
        corr_d  = (sign_a ? in_src2 : '0) + (sign_b ? in_src1 : '0);
    end

    generate
        if (STAGES > 1) begin : g_pp_stage
            logic [DATA_W-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
            logic [DATA_W-1:0] corr_q;
            logic [1:0]        op_q;

            // First stage holds the partial products and the correction term.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pp_ll_q <= '0;
                    pp_lh_q <= '0;
                    pp_hl_q <= '0;
                    pp_hh_q <= '0;
                    corr_q  <= '0;
                    op_q    <= '0;
                end else if (advance) begin
                    pp_ll_q <= pp_ll_d;
                    pp_lh_q <= pp_lh_d;
                    pp_hl_q <= pp_hl_d;
                    pp_hh_q <= pp_hh_d;
                    corr_q  <= corr_d;
                    op_q    <= in_op;
                end
            end

            assign pp_ll_s = pp_ll_q;
            assign pp_lh_s = pp_lh_q;
            assign pp_hl_s = pp_hl_q;
            assign pp_hh_s = pp_hh_q;
            assign corr_s  = corr_q;
            assign op_s    = op_q;
        end else begin : g_pp_direct
            assign pp_ll_s = pp_ll_d;
            assign pp_lh_s = pp_lh_d;
            assign pp_hl_s = pp_hl_d;
            assign pp_hh_s = pp_hh_d;
            assign corr_s  = corr_d;
            assign op_s    = in_op;
        end
    endgenerate

    // Sum the partial products, apply the sign correction, pick the word.
    always_comb begin
        full_prod = {pp_hh_s, pp_ll_s}
                  + {{HALF_W{1'b0}}, pp_lh_s, {HALF_W{1'b0}}}
                  + {{HALF_W{1'b0}}, pp_hl_s, {HALF_W{1'b0}}}
                  - {corr_s, {DATA_W{1'b0}}};
        res_d = (op_s == 2'b00) ? full_prod[DATA_W-1:0] : full_prod[2*DATA_W-1:DATA_W];
`ifdef CPU_MULT_PIPE_OVF_EN
        ovf_d = (op_s == 2'b00) &&
                (full_prod[2*DATA_W-1:DATA_W] != {DATA_W{full_prod[DATA_W-1]}});
`endif
    end

    // Result word (and overflow flag) shift register; stage 0 takes the fresh sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RES_STAGES; i++) begin
                res_q[i] <= '0;
`ifdef CPU_MULT_PIPE_OVF_EN
                ovf_q[i] <= 1'b0;
`endif
            end
        end else if (advance) begin
            res_q[0] <= res_d;
`ifdef CPU_MULT_PIPE_OVF_EN
            ovf_q[0] <= ovf_d;
`endif
            for (int i = 1; i < RES_STAGES; i++) begin
                res_q[i] <= res_q[i-1];
`ifdef CPU_MULT_PIPE_OVF_EN
                ovf_q[i] <= ovf_q[i-1];
`endif
            end
        end
    end

    // Valid bits and tags. Flush clears the valids and blocks the accept that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i] <= 1'b0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // busy reports any occupied stage.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            busy = busy | vld_q[i];
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign out_result = res_q[RES_STAGES-1];
`ifdef CPU_MULT_PIPE_OVF_EN
    assign out_ovf    = ovf_q[RES_STAGES-1];
`endif

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Testbench for cpu_mult_pipe with DATA_W=32, STAGES=2, TAG_W=5.
// A negedge monitor keeps a scoreboard: each accepted operation pushes its
// reference result, and each delivered result pops the queue and is compared.
// The scenario tasks also check timing and stall behaviour directly.

module tb_cpu_mult_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [1:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;
`ifdef CPU_MULT_PIPE_OVF_EN
    logic        out_ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int rx_count     = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t push_e;

    cpu_mult_pipe #(.DATA_W(32), .STAGES(2), .TAG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
`ifdef CPU_MULT_PIPE_OVF_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model built from 64-bit sign/zero-extended products.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] sa, sb, za, zb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'h0, a};
        zb = {32'h0, b};
        case (op)
            2'b00:   p = za * zb;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * zb;
            default: p = za * zb;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: pop and compare on delivery, push on accept.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: result %h tag %0d delivered with nothing outstanding", out_result, out_tag);
                end else begin
                    mon_e = sb_q.pop_front();
                    rx_count++;
                    if (out_result !== mon_e.res || out_tag !== mon_e.tag) begin
                        tests_failed++;
                        $display("FAIL sb_result: got %h tag %0d, expected %h tag %0d",
                                 out_result, out_tag, mon_e.res, mon_e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_e.res = model(in_src1, in_src2, in_op);
                push_e.tag = in_tag;
                sb_q.push_back(push_e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [4:0] tag);
        in_valid = v;
        in_src1  = a;
        in_src2  = b;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h1234_5678, 32'h0000_0003, 2'b00, 5'd7);
        repeat (3) cyc();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (out_result !== 32'h0) begin tests_failed++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
        tests_run++;
        if (out_tag !== 5'd0) begin tests_failed++; $display("FAIL reset_out_tag: got %0d expected 0", out_tag); end
        cyc();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_after: got %b expected 0", busy); end
        cyc();
    endtask

    task automatic test_basic();
        drive(1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 2'b00, 5'd3);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
        cyc();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b expected 1", busy); end
        cyc();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency: out_valid %b expected 1", out_valid); end
        tests_run++;
        if (out_result !== 32'hFFFE_0001) begin tests_failed++; $display("FAIL basic_result: got %h expected fffe0001", out_result); end
        tests_run++;
        if (out_tag !== 5'd3) begin tests_failed++; $display("FAIL basic_tag: got %0d expected 3", out_tag); end
        cyc();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_bubble: out_valid %b expected 0", out_valid); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp4 [4];
        exp4[0] = 32'h0000_0001;
        exp4[1] = 32'h0000_0000;
        exp4[2] = 32'hFFFF_FFFF;
        exp4[3] = 32'hFFFF_FFFE;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'(i), 5'(10 + i));
            else       drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
            @(negedge clk);
            if (i >= 2) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_result !== exp4[i-2]) begin
                    tests_failed++;
                    $display("FAIL b2b_op%0d: valid %b result %h, expected valid 1 result %h",
                             i - 2, out_valid, out_result, exp4[i-2]);
                end
            end
            cyc();
        end
    endtask

    task automatic test_stall();
        logic [31:0] st_a [4];
        logic [31:0] st_b [4];
        logic [1:0]  st_op [4];
        logic [31:0] held;
        int idx;
        int rx0;
        st_a[0] = 32'h1234_5678; st_b[0] = 32'h9ABC_DEF0; st_op[0] = 2'b01;
        st_a[1] = 32'hFFFF_0000; st_b[1] = 32'h0000_0003; st_op[1] = 2'b00;
        st_a[2] = 32'h8000_0000; st_b[2] = 32'h8000_0000; st_op[2] = 2'b10;
        st_a[3] = 32'h7FFF_FFFF; st_b[3] = 32'hFFFF_FFFF; st_op[3] = 2'b11;
        held = model(st_a[0], st_b[0], st_op[0]);
        idx  = 0;
        rx0  = rx_count;
        for (int k = 0; k < 40 && (idx < 4 || sb_q.size() != 0); k++) begin
            out_ready = (k < 5) ? 1'b0 : 1'b1;
            if (idx < 4) drive(1'b1, st_a[idx], st_b[idx], st_op[idx], 5'(8 + idx));
            else         drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                tests_run++;
                if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready_k%0d: got %b expected 0", k, in_ready); end
                tests_run++;
                if (out_valid !== 1'b1 || out_result !== held || out_tag !== 5'd8) begin
                    tests_failed++;
                    $display("FAIL stall_hold_k%0d: valid %b result %h tag %0d, expected 1 %h 8",
                             k, out_valid, out_result, out_tag, held);
                end
            end
            if (in_valid && in_ready) idx++;
            cyc();
        end
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        tests_run++;
        if (idx != 4 || sb_q.size() != 0 || rx_count - rx0 != 4) begin
            tests_failed++;
            $display("FAIL stall_delivery: accepted %0d outstanding %0d delivered %0d, expected 4 0 4",
                     idx, sb_q.size(), rx_count - rx0);
        end
    endtask

    task automatic test_reset_inflight();
        int cnt;
        drive(1'b1, 32'h1234_5678, 32'h0000_0011, 2'b00, 5'd20);
        cyc();
        drive(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 2'b11, 5'd21);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_fl_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_fl_busy: got %b expected 0", busy); end
        tests_run++;
        if (out_result !== 32'h0) begin tests_failed++; $display("FAIL rst_fl_out_result: got %h expected 0", out_result); end
        cyc();
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
            cyc();
        end
        tests_run++;
        if (cnt != 0) begin tests_failed++; $display("FAIL rst_fl_stale: %0d stale results, expected 0", cnt); end
    endtask

    task automatic test_flush();
        int cnt;
        drive(1'b1, 32'h0000_0100, 32'h0000_0200, 2'b00, 5'd5);
        cyc();
        drive(1'b1, 32'h0000_0300, 32'h0000_0400, 2'b00, 5'd6);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b expected 0", busy); end
        cyc();
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
            cyc();
        end
        tests_run++;
        if (cnt != 0) begin tests_failed++; $display("FAIL flush_out_valid: %0d results after flush, expected 0", cnt); end
    endtask

`ifdef CPU_MULT_PIPE_OVF_EN
    task automatic test_ovf();
        drive(1'b1, 32'h0001_0000, 32'h0001_0000, 2'b00, 5'd1);
        cyc();
        drive(1'b1, 32'h0000_7FFF, 32'h0000_0002, 2'b00, 5'd2);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'h0 || out_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: valid %b result %h ovf %b, expected 1 00000000 1", out_valid, out_result, out_ovf);
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'h0000_FFFE || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: valid %b result %h ovf %b, expected 1 0000fffe 0", out_valid, out_result, out_ovf);
        end
        cyc();
    endtask
`endif

    task automatic test_random();
        int acc;
        int rx0;
        acc = 0;
        rx0 = rx_count;
        for (int k = 0; k < 300; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc();
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) cyc();
        tests_run++;
        if (sb_q.size() != 0 || rx_count - rx0 != acc) begin
            tests_failed++;
            $display("FAIL random_drain: outstanding %0d delivered %0d, expected 0 outstanding and %0d delivered",
                     sb_q.size(), rx_count - rx0, acc);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_flush();
`ifdef CPU_MULT_PIPE_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
